// File: rtl/piso_shift_reg.sv
// ---------------------------------------------------------------------------------------------
// piso_shift_reg
//   Parallel-in, serial-out shift register. A DATA_WIDTH word is captured on a load handshake
//   (in_Load & out_ready) and then emitted one bit per enabled cycle (in_En & out_bit_valid).
//   A three-state FSM (idle, shift, done) plus a bits-remaining counter sequence each word.
//
//   Build option: define PISO_LSB_FIRST_EN to transmit LSB-first (shift right, 0 filled at the
//   MSB). Left undefined, the word goes out MSB-first (shift left, 0 filled at bit 0).
//
// Ports
//   in_Clk         clock, rising edge
//   in_Rst         asynchronous active-high reset
//   in_Load        load request, honoured only while out_ready
//   in_data        parallel word to transmit
//   in_En          shift enable, consumes the presented bit while out_bit_valid
//   out_ready      high only when idle
//   out_shift_out  current serial bit (register output)
//   out_bit_valid  high while a bit is presented
//   out_done       one-cycle pulse after the last bit is consumed
// ---------------------------------------------------------------------------------------------
module piso_shift_reg #(
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_Load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_En,
  output logic                  out_ready,
  output logic                  out_shift_out,
  output logic                  out_bit_valid,
  output logic                  out_done
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CntLoad = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_Load) begin
          sreg_d  = in_data;
          cnt_d   = CntLoad;
          state_d = StShift;
        end
      end
      StShift: begin
        // in_Load is deliberately ignored here: a busy word is never overwritten.
        if (in_En) begin
`ifdef PISO_LSB_FIRST_EN
          sreg_d = sreg_q >> 1;
`else
          sreg_d = sreg_q << 1;
`endif
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered: decode them from the next state.
    ready_d = (state_d == StIdle);
    valid_d = (state_d == StShift);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign out_ready     = ready_q;
  assign out_bit_valid = valid_q;
  assign out_done      = done_q;

  // The shift register is zero outside a word, so the serial bit is 0 when not valid.
`ifdef PISO_LSB_FIRST_EN
  assign out_shift_out = sreg_q[0];
`else
  assign out_shift_out = sreg_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// ---------------------------------------------------------------------------------------------
// tb_piso_shift_reg
//   Self-checking bench for piso_shift_reg. A queue of bits still to be transmitted serves as
//   the reference model; a loopback receiver rebuilds each word from the serial output.
//   Word width is 24 in the default build and 8 with PISO_LSB_FIRST_EN.
// ---------------------------------------------------------------------------------------------
module tb_piso_shift_reg;

`ifdef PISO_LSB_FIRST_EN
  localparam int unsigned W = 8;
`else
  localparam int unsigned W = 24;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] data;
  logic         en;
  logic         out_ready;
  logic         out_shift_out;
  logic         out_bit_valid;
  logic         out_done;

  piso_shift_reg #(
    .DATA_WIDTH(W)
  ) dut (
    .in_Clk       (clk),
    .in_Rst       (rst),
    .in_Load      (load),
    .in_data      (data),
    .in_En        (en),
    .out_ready    (out_ready),
    .out_shift_out(out_shift_out),
    .out_bit_valid(out_bit_valid),
    .out_done     (out_done)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  // Reference model: bits still owed on the wire, and whether a done pulse is due this cycle.
  bit           exp_q[$];
  bit           m_done = 1'b0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] rx = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_valid;
    logic exp_bit;
    exp_valid = (exp_q.size() != 0);
    exp_bit   = exp_valid ? exp_q[0] : 1'b0;
    check_eq({tag, "_valid"}, 32'(out_bit_valid), 32'(exp_valid));
    check_eq({tag, "_bit"},   32'(out_shift_out), 32'(exp_bit));
    check_eq({tag, "_done"},  32'(out_done),      32'(m_done));
    check_eq({tag, "_ready"}, 32'(out_ready),     32'(!exp_valid && !m_done));
  endtask

  function automatic logic [W-1:0] word_of(input logic [31:0] v);
    return v[W-1:0];
  endfunction

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input logic l, input logic [W-1:0] d, input logic e);
    bit done_next;
    @(negedge clk);
    load = l;
    data = d;
    en   = e;
    // Loopback receiver, clocked by the same enable as the transmitter.
    if (out_bit_valid && e) begin
`ifdef PISO_LSB_FIRST_EN
      rx = (rx >> 1) | (W'(out_shift_out) << (W - 1));
`else
      rx = (rx << 1) | W'(out_shift_out);
`endif
    end
    done_next = 1'b0;
    if (exp_q.size() != 0) begin
      if (e) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_next = 1'b1;
      end
    end else if (!m_done && l) begin
      m_word = d;
      for (int i = 0; i < int'(W); i++) begin
`ifdef PISO_LSB_FIRST_EN
        exp_q.push_back(d[i]);
`else
        exp_q.push_back(d[int'(W) - 1 - i]);
`endif
      end
    end
    m_done = done_next;
    @(posedge clk);
    #1;
    check_outputs("cyc");
    if (m_done) check_eq("loopback", 32'(rx), 32'(m_word));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_done = 1'b0;
    #1;
    check_outputs("rst");
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    en   = 1'b0;
    data = '0;
    #2;
    check_outputs("t1_por");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b1);

    // T1: reset pulsed while idle.
    do_reset();
    step(1'b0, '0, 1'b0);

    // T2 / T6: directed words with enable held high.
    step(1'b1, word_of(32'hA5C3F0), 1'b1);
    repeat (W + 3) step(1'b0, '0, 1'b1);
    step(1'b1, word_of(32'h01), 1'b1);
    repeat (W + 3) step(1'b0, '0, 1'b1);

    // T3: stall for 5 cycles after the first bit is presented.
    step(1'b1, word_of(32'h800001), 1'b1);
    repeat (5) step(1'b0, '0, 1'b0);
    repeat (W + 2) step(1'b0, '0, 1'b1);

    // T4: load requests while busy must be ignored.
    step(1'b1, word_of(32'h3C5A96), 1'b1);
    repeat (W - 2) step(1'b1, word_of(32'hFFFFFF), 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);

    // T5: reset mid-word, then a clean word.
    step(1'b1, word_of(32'h5A5A5A), 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b1);
    step(1'b1, word_of(32'hC0FFEE), 1'b1);
    repeat (W + 2) step(1'b0, '0, 1'b1);

    // Randomised traffic with sparse enables, loads and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
